hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RV32 core. Sits beside the opcode
//  decoder and drives the stage-register write enables, flushes and control bubbles.
//  Arbitrates three events by priority: data-memory wait, EX-stage redirect, load-use hazard.
//  Also enforces a bounded data-memory wait with a timeout and abort.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles before a data access is aborted (>=2)
//  CNT_W        32  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1  core clock, rising edge
//  rst           in   1  asynchronous, active-high reset
//  id_rs1        in   5  rs1 of instruction in ID
//  id_rs2        in   5  rs2 of instruction in ID
//  id_use_rs1    in   1  ID instruction reads rs1
//  id_use_rs2    in   1  ID instruction reads rs2
//  ex_rd         in   5  rd of instruction in EX
//  ex_MemRead    in   1  EX instruction is a load
//  ex_redirect   in   1  EX resolved taken branch / jal / jalr
//  mem_req       in   1  MEM instruction has MemRead|MemWrite
//  dmem_ready    in   1  data memory completes access this cycle
//  PCWrite       out  1  PC update enable
//  IFIDWrite     out  1  IF/ID register enable
//  IDEXWrite     out  1  ID/EX register enable
//  EXMEMWrite    out  1  EX/MEM register enable
//  ctrl_bubble   out  1  zero control signals into ID/EX
//  IFID_flush    out  1  clear IF/ID to NOP
//  IDEX_flush    out  1  clear ID/EX to NOP
//  mem_abort     out  1  one-cycle pulse: current MEM access dropped
//  mem_err       out  1  sticky: a timeout has occurred
// BEHAVIOUR
//  Clock/reset: one clock domain, clk. rst is asynchronous and active-high.
//  Reset values:
//  - state=RUN, wait_cnt=0, mem_err=0.
//  - While rst=1: PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, all flush/bubble/abort=0.
//  Combinational conditions:
//  - lu_haz = ex_MemRead & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - freeze = mem_req & ~dmem_ready & ~timeout.
//  - timeout = state==WAIT & wait_cnt==MEM_TIMEOUT-1.
//  Output priority (outputs combinational, zero latency):
//  1 freeze: all four write enables=0; no flush or bubble (pipeline frozen, EX redirect held).
//  2 ex_redirect: all enables=1; IFID_flush=1, IDEX_flush=1; load-use hazard ignored.
//  3 lu_haz: PCWrite=IFIDWrite=0; IDEXWrite=EXMEMWrite=1; ctrl_bubble=1 (single-cycle stall).
//  4 otherwise: all enables=1, flush/bubble=0.
//  FSM:
//  - RUN->WAIT: on freeze; wait_cnt<=1.
//  - WAIT stays while freeze; wait_cnt increments and saturates.
//  - WAIT->RUN: on dmem_ready, or on timeout. wait_cnt<=0.
//  - Timeout cycle: mem_abort=1, mem_err<=1, freeze deasserted; pipeline advances, priorities 2-4 apply.
//  Boundary cases:
//  - dmem_ready high in the first request cycle: no freeze, FSM stays in RUN.
//  - dmem_ready and timeout coincide: ready wins, no abort.
//  - mem_req drops while in WAIT (not expected): return to RUN, no abort.
//  - mem_err clears only on rst. rst mid-WAIT returns to RUN immediately.
// CONFIGURATION
//  PERF_CNT_EN defined: adds outputs stall_cycles and flush_events (CNT_W each), reset 0.
//  - stall_cycles += 1 each cycle freeze or lu_haz (and not redirect).
//  - flush_events += 1 each redirect cycle not frozen.
//  - Both counters wrap at 2^CNT_W.
//  PERF_CNT_EN undefined: no counters or ports; all other behaviour identical.
// TESTING
//  1 Load-use: ex_MemRead=1, ex_rd=5, id_rs1=5, id_use_rs1=1
//    -> PCWrite=0, IFIDWrite=0, ctrl_bubble=1 for exactly 1 cycle.
//  2 ex_rd=0 with matching rs1=0 -> no stall. id_use_rs2=0 with rs2 match -> no stall.
//  3 Redirect with lu_haz in same cycle -> IFID_flush=IDEX_flush=1, ctrl_bubble=0, PCWrite=1.
//  4 mem_req=1, dmem_ready low 3 cycles then high
//    -> enables 0 for 3 cycles, 1 on 4th; mem_abort never asserted.
//  5 mem_req=1, dmem_ready never high (MEM_TIMEOUT=16)
//    -> 15 frozen cycles, then mem_abort pulse on 16th cycle; mem_err=1 until rst.
//  6 rst asserted mid-WAIT, asynchronously -> all enables 0 at once, state RUN, mem_err=0.
//    With PERF_CNT_EN: counters read 0 after reset.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: stage enables, flushes, bubbles, dmem timeout.
// Optional performance counters are compiled in with `define PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_MemRead,
  input  logic       ex_redirect,
  input  logic       mem_req,
  input  logic       dmem_ready,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IDEXWrite,
  output logic       EXMEMWrite,
  output logic       ctrl_bubble,
  output logic       IFID_flush,
  output logic       IDEX_flush,
  output logic       mem_abort,
  output logic       mem_err
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
`endif
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, WAIT} state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_nx;
  logic          lu_haz;
  logic          timeout;
  logic          freeze;
  logic          rs1_hit;
  logic          rs2_hit;

  // Hazard and wait-bound conditions
  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    lu_haz  = ex_MemRead && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    timeout = (state == WAIT) && (wait_cnt == CNT_LAST);
    freeze  = mem_req && !dmem_ready && !timeout;
  end

  // Prioritised stage controls; everything held off while in reset
  always_comb begin
    PCWrite     = 1'b0;
    IFIDWrite   = 1'b0;
    IDEXWrite   = 1'b0;
    EXMEMWrite  = 1'b0;
    ctrl_bubble = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    mem_abort   = 1'b0;
    if (!rst) begin
      mem_abort = timeout && mem_req && !dmem_ready;
      if (freeze) begin
        PCWrite    = 1'b0;
      end else if (ex_redirect) begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        EXMEMWrite = 1'b1;
        IFID_flush = 1'b1;
        IDEX_flush = 1'b1;
      end else if (lu_haz) begin
        IDEXWrite   = 1'b1;
        EXMEMWrite  = 1'b1;
        ctrl_bubble = 1'b1;
      end else begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        EXMEMWrite = 1'b1;
      end
    end
  end

  // Wait FSM next state and wait counter update
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    unique case (state)
      RUN: begin
        if (freeze) begin
          state_nx    = WAIT;
          wait_cnt_nx = CW'(1);
        end
      end
      WAIT: begin
        if (freeze) begin
          if (wait_cnt != CNT_LAST)
            wait_cnt_nx = wait_cnt + CW'(1);
        end else begin
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end
      end
      default: begin
        state_nx    = RUN;
        wait_cnt_nx = '0;
      end
    endcase
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (mem_abort)
        mem_err <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  // Stall and flush event counters, free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (freeze || (lu_haz && !ex_redirect))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (ex_redirect && !freeze)
        flush_events <= flush_events + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
// Table of single-cycle vectors plus multi-cycle wait/timeout/reset sequences.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_MemRead, ex_redirect, mem_req, dmem_ready;
  logic       PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic       ctrl_bubble, IFID_flush, IDEX_flush, mem_abort, mem_err;
`ifdef PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [7:0] O_RUN = 8'b1111_0000;
  localparam logic [7:0] O_STL = 8'b0011_1000;
  localparam logic [7:0] O_RED = 8'b1111_0110;
  localparam logic [7:0] O_FRZ = 8'b0000_0000;
  localparam logic [7:0] O_ABT = 8'b1111_0001;

  typedef struct {
    string      nm;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, red, req, rdy;
    logic [7:0] exp;
  } vec_t;

  hazard_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .ex_redirect(ex_redirect), .mem_req(mem_req),
    .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IDEXWrite(IDEXWrite), .EXMEMWrite(EXMEMWrite),
    .ctrl_bubble(ctrl_bubble), .IFID_flush(IFID_flush),
    .IDEX_flush(IDEX_flush), .mem_abort(mem_abort),
    .mem_err(mem_err)
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles)
    , .flush_events(flush_events)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
            ctrl_bubble, IFID_flush, IDEX_flush, mem_abort};
  endfunction

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_MemRead = v.mr; ex_redirect = v.red;
    mem_req = v.req; dmem_ready = v.rdy;
  endtask

  // One cycle: drive at negedge, check 2ns later (well before posedge)
  task automatic step(input vec_t v, input logic err);
    @(negedge clk);
    drive(v);
    #2;
    chk(v.nm, {outs(), mem_err}, {v.exp, err});
  endtask

  function automatic vec_t mk(input string nm, input logic req,
                              input logic rdy, input logic red,
                              input logic [7:0] exp);
    vec_t v;
    v.nm = nm; v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = 5'd9;
    v.u1 = 1'b1; v.u2 = 1'b1; v.mr = 1'b0;
    v.red = red; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    tbl[0] = '{"lu_rs1", 5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, O_STL};
    tbl[1] = '{"lu_gone", 5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 0, 0, O_RUN};
    tbl[2] = '{"rd_zero", 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, O_RUN};
    tbl[3] = '{"rs2_unused", 5'd3, 5'd7, 5'd7, 1, 0, 1, 0, 0, 0, O_RUN};
    tbl[4] = '{"lu_rs2", 5'd3, 5'd7, 5'd7, 1, 1, 1, 0, 0, 0, O_STL};
    tbl[5] = '{"rs1_unused", 5'd7, 5'd3, 5'd7, 0, 1, 1, 0, 0, 0, O_RUN};
    tbl[6] = '{"redir_lu", 5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, O_RED};
    tbl[7] = '{"redir", 5'd1, 5'd2, 5'd9, 1, 1, 0, 1, 0, 0, O_RED};
    tbl[8] = '{"ready_first", 5'd1, 5'd2, 5'd9, 1, 1, 0, 0, 1, 1, O_RUN};
    tbl[9] = '{"ready_lu", 5'd9, 5'd2, 5'd9, 1, 1, 1, 0, 1, 1, O_STL};

    // Reset state
    rst = 1'b1;
    drive(mk("idle", 0, 0, 0, O_RUN));
    #12;
    chk("reset_outs", {outs(), mem_err}, 9'b0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational priority table in RUN
    foreach (tbl[i]) step(tbl[i], 1'b0);

    // Three wait cycles then ready; redirect held during freeze
    step(mk("wait1", 1, 0, 0, O_FRZ), 1'b0);
    step(mk("wait2_redir", 1, 0, 1, O_FRZ), 1'b0);
    step(mk("wait3", 1, 0, 0, O_FRZ), 1'b0);
    step(mk("wait_done", 1, 1, 0, O_RUN), 1'b0);
    step(mk("after_wait", 0, 0, 0, O_RUN), 1'b0);

    // Ready coincides with the timeout cycle: no abort
    for (int i = 0; i < 15; i++)
      step(mk("coin_frz", 1, 0, 0, O_FRZ), 1'b0);
    step(mk("coin_ready", 1, 1, 0, O_RUN), 1'b0);
    step(mk("coin_after", 0, 0, 0, O_RUN), 1'b0);

    // Request drops while waiting: no abort, fresh wait afterwards
    step(mk("drop_frz1", 1, 0, 0, O_FRZ), 1'b0);
    step(mk("drop_frz2", 1, 0, 0, O_FRZ), 1'b0);
    step(mk("drop_req", 0, 0, 0, O_RUN), 1'b0);

    // Full timeout: 15 frozen cycles then abort pulse, sticky error
    for (int i = 0; i < 15; i++)
      step(mk("to_frz", 1, 0, 0, O_FRZ), 1'b0);
    step(mk("to_abort", 1, 0, 0, O_ABT), 1'b0);
    step(mk("to_after", 0, 0, 0, O_RUN), 1'b1);
    step(mk("err_sticky", 0, 0, 1, O_RED), 1'b1);

    // Asynchronous reset in the middle of a wait
    step(mk("rw_frz1", 1, 0, 0, O_FRZ), 1'b1);
    step(mk("rw_frz2", 1, 0, 0, O_FRZ), 1'b1);
    step(mk("rw_frz3", 1, 0, 0, O_FRZ), 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst", {outs(), mem_err}, 9'b0);
    @(negedge clk);
    rst = 1'b0;
    step(mk("post_rst", 0, 0, 0, O_RUN), 1'b0);

    // Wait counter restarted from zero: another full 15+1 window
    for (int i = 0; i < 15; i++)
      step(mk("post_frz", 1, 0, 0, O_FRZ), 1'b0);
    step(mk("post_abort", 1, 0, 0, O_ABT), 1'b0);
    step(mk("post_err", 0, 0, 0, O_RUN), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
